// File: rtl/cache_pkg.sv
// cache_pkg -- shared definitions for the cache-side request path.
//
// Contents:
//   OP_RD / OP_WR / OP_NOOP  2-bit core operation encodings (2'b10 is treated
//                            as NOOP by every consumer)
//   arb_state_e              cache_bus_arbiter FSM states
//   is_mem_op()              true for an operation that needs the cache port
package cache_pkg;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_NOOP = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        WAIT  = 2'b10,
        FIN   = 2'b11
    } arb_state_e;

    // Only RD and WR occupy the cache port; both NOOP codes are ignored.
    function automatic logic is_mem_op(input logic [1:0] o);
        return (o == OP_RD) || (o == OP_WR);
    endfunction

endpackage

// File: rtl/cache_bus_arbiter_rr_pick.sv
// rr_pick -- combinational round-robin winner selection.
//
// Scans the eligible vector upward starting at ptr, wrapping at N, and
// reports the first set position.
//
// Ports:
//   eligible   in  N   per-requester eligibility
//   ptr        in  IW  index with the highest priority this round
//   winner     out N   one-hot winner (all zero when nothing is eligible)
//   index      out IW  binary index of the winner
//   any_valid  out 1   at least one requester is eligible
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  winner,
    output logic [IW-1:0] index,
    output logic          any_valid
);

    // Rotating priority scan; the first hit latches and later hits are masked
    always_comb begin
        int          pos;
        logic [IW-1:0] pos_w;
        logic        found;
        logic        take;
        winner = '0;
        index  = '0;
        found  = 1'b0;
        pos    = 0;
        pos_w  = '0;
        take   = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos           = int'(ptr) + k;
            pos           = (pos >= N) ? (pos - N) : pos;
            pos_w         = IW'(pos);
            take          = !found && eligible[pos_w];
            winner[pos_w] = winner[pos_w] | take;
            index         = take ? pos_w : index;
            found         = found | take;
        end
        any_valid = found;
    end

endmodule

// File: rtl/cache_bus_arbiter.sv
// cache_bus_arbiter -- shares the single cache data port among NCORES cores.
//
// A round-robin winner is chosen in IDLE, its op/addr/wdata are latched and
// presented to the cache with a valid/ready handshake. After the cache
// reports completion, read data/hit are returned with a one-cycle done pulse
// on the winner's lane, and priority moves to the core after the winner.
//
// Build option: define ARB_TIMEOUT_EN to add a grant-to-completion watchdog.
// A transaction still outstanding TIMEOUT cycles after ISSUE entry finishes
// with err = 1, rdata = 0 and a one-cycle c_abort pulse. Without the macro,
// err and c_abort are tied low and the block waits for c_done indefinitely.
//
// Ports:
//   clk, rst (async, active-low)
//   req/op/addr/wdata    core-side requests, core i in slice i
//   gnt                  one-hot grant, held through the FIN cycle
//   done                 one-cycle completion pulse to the winner
//   err, rdata, hit      completion status/data, valid with done
//   c_valid/c_op/c_addr/c_wdata, c_ready   command handshake to cache
//   c_done/c_rdata/c_hit                  completion from cache
//   c_abort              one-cycle abort pulse on timeout
module cache_bus_arbiter
    import cache_pkg::*;
#(
    parameter int NCORES  = 4,
    parameter int AW      = 16,
    parameter int DW      = 32,
    parameter int TIMEOUT = 64
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NCORES-1:0]    req,
    input  logic [2*NCORES-1:0]  op,
    input  logic [AW*NCORES-1:0] addr,
    input  logic [DW*NCORES-1:0] wdata,
    output logic [NCORES-1:0]    gnt,
    output logic [NCORES-1:0]    done,
    output logic                 err,
    output logic [DW-1:0]        rdata,
    output logic                 hit,
    output logic                 c_valid,
    output logic [1:0]           c_op,
    output logic [AW-1:0]        c_addr,
    output logic [DW-1:0]        c_wdata,
    input  logic                 c_ready,
    input  logic                 c_done,
    input  logic [DW-1:0]        c_rdata,
    input  logic                 c_hit,
    output logic                 c_abort
);

    localparam int IW = (NCORES > 1) ? $clog2(NCORES) : 1;

    arb_state_e        state_r;
    logic [IW-1:0]     ptr_r;
    logic [IW-1:0]     win_r;
    logic [NCORES-1:0] gnt_r;
    logic [NCORES-1:0] done_r;
    logic [DW-1:0]     rdata_r;
    logic              hit_r;
    logic              c_valid_r;
    logic [1:0]        c_op_r;
    logic [AW-1:0]     c_addr_r;
    logic [DW-1:0]     c_wdata_r;

    logic [NCORES-1:0] eligible_s;
    logic [NCORES-1:0] pick_onehot_s;
    logic [IW-1:0]     pick_idx_s;
    logic              any_s;
    logic [1:0]        sel_op_s;
    logic [AW-1:0]     sel_addr_s;
    logic [DW-1:0]     sel_wdata_s;
    logic [IW-1:0]     next_ptr_s;
    logic              timeout_s;
    logic              real_done_s;
    logic              to_s;
    logic              fin_entry_s;

    // Per-core eligibility: request raised with a real RD/WR operation
    always_comb begin
        eligible_s = '0;
        for (int i = 0; i < NCORES; i++) begin
            eligible_s[i] = req[i] && is_mem_op(op[2*i +: 2]);
        end
    end

    rr_pick #(
        .N  (NCORES),
        .IW (IW)
    ) u_rr_pick (
        .eligible  (eligible_s),
        .ptr       (ptr_r),
        .winner    (pick_onehot_s),
        .index     (pick_idx_s),
        .any_valid (any_s)
    );

    // AND-OR mux of the winning core's command fields (winner is one-hot)
    always_comb begin
        sel_op_s    = 2'b00;
        sel_addr_s  = '0;
        sel_wdata_s = '0;
        for (int i = 0; i < NCORES; i++) begin
            sel_op_s    = sel_op_s    | (op[2*i +: 2]     & {2{pick_onehot_s[i]}});
            sel_addr_s  = sel_addr_s  | (addr[AW*i +: AW] & {AW{pick_onehot_s[i]}});
            sel_wdata_s = sel_wdata_s | (wdata[DW*i +: DW] & {DW{pick_onehot_s[i]}});
        end
    end

    // Priority moves to the core just after the winner, wrapping at NCORES
    always_comb begin
        if (win_r == IW'(NCORES - 1)) begin
            next_ptr_s = '0;
        end else begin
            next_ptr_s = win_r + IW'(1);
        end
    end

    // Completion detection; c_done in ISSUE without c_ready is ignored
    always_comb begin
        real_done_s = 1'b0;
        case (state_r)
            ISSUE:   real_done_s = c_ready && c_done;
            WAIT:    real_done_s = c_done;
            default: real_done_s = 1'b0;
        endcase
        to_s        = timeout_s && !real_done_s;
        fin_entry_s = real_done_s || to_s;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt_r;
    logic          err_r;
    logic          abort_r;

    // Transaction age: zero while IDLE, so it reads 0 in the first ISSUE cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r <= '0;
        end else if (state_r == IDLE) begin
            cnt_r <= '0;
        end else if (cnt_r != CW'(TIMEOUT)) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign timeout_s = ((state_r == ISSUE) || (state_r == WAIT)) &&
                       (cnt_r == CW'(TIMEOUT - 1));

    // Timeout status, aligned with the done pulse in the FIN cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_r   <= 1'b0;
            abort_r <= 1'b0;
        end else if (fin_entry_s) begin
            err_r   <= to_s;
            abort_r <= to_s;
        end else begin
            err_r   <= 1'b0;
            abort_r <= 1'b0;
        end
    end

    assign err     = err_r;
    assign c_abort = abort_r;
`else
    logic timeout_unused_s;
    assign timeout_unused_s = (TIMEOUT > 0);
    assign timeout_s        = 1'b0;
    assign err              = 1'b0;
    assign c_abort          = 1'b0;
`endif

    // Main arbitration / handshake FSM and command latches
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            ptr_r     <= '0;
            win_r     <= '0;
            gnt_r     <= '0;
            done_r    <= '0;
            rdata_r   <= '0;
            hit_r     <= 1'b0;
            c_valid_r <= 1'b0;
            c_op_r    <= OP_NOOP;
            c_addr_r  <= '0;
            c_wdata_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (any_s) begin
                        state_r   <= ISSUE;
                        win_r     <= pick_idx_s;
                        gnt_r     <= pick_onehot_s;
                        c_valid_r <= 1'b1;
                        c_op_r    <= sel_op_s;
                        c_addr_r  <= sel_addr_s;
                        c_wdata_r <= sel_wdata_s;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                ISSUE, WAIT: begin
                    if (fin_entry_s) begin
                        state_r   <= FIN;
                        c_valid_r <= 1'b0;
                        done_r    <= gnt_r;
                        rdata_r   <= to_s ? '0 : c_rdata;
                        hit_r     <= to_s ? 1'b0 : c_hit;
                    end else if ((state_r == ISSUE) && c_ready) begin
                        state_r   <= WAIT;
                        c_valid_r <= 1'b0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                FIN: begin
                    state_r <= IDLE;
                    done_r  <= '0;
                    gnt_r   <= '0;
                    ptr_r   <= next_ptr_s;
                end
                default: begin
                    state_r   <= IDLE;
                    done_r    <= '0;
                    gnt_r     <= '0;
                    c_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_r;
    assign done    = done_r;
    assign rdata   = rdata_r;
    assign hit     = hit_r;
    assign c_valid = c_valid_r;
    assign c_op    = c_op_r;
    assign c_addr  = c_addr_r;
    assign c_wdata = c_wdata_r;

endmodule
